// File: rtl/bilin_pkg.sv
// Shared types and constants for the bilinear fetch controller.
// Fixed-point layout: coordinates are Q6.7, pixel weights Q0.14.
package bilin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int FRAC_W  = 7;
  localparam int INT_W   = 6;
  localparam int COORD_W = INT_W + FRAC_W;
  localparam int ONE     = 128;
  localparam int WGT_W   = 16;
  localparam int ACC_W   = 23;
  localparam int PIX_W   = 8;
  localparam int ROUND   = 1 << (2 * FRAC_W - 1);

  // Round the Q0.14-scaled sum to an integer pixel and saturate at 255.
  function automatic logic [PIX_W-1:0] round_sat_pix(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] sum;
    logic [9:0]     q;
    sum = {1'b0, acc} + (ACC_W + 1)'(ROUND);
    q   = 10'(sum >> (2 * FRAC_W));
    if (q > 10'd255) begin
      return 8'hFF;
    end else begin
      return q[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bilin_fetch_ctrl_if.sv
// Request / pixel-memory / result bundle of the bilinear fetch controller.
// The controller uses the slave view; the requester/memory/consumer side
// uses the master view.
interface bilin_fetch_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [12:0]       req_x;
  logic [12:0]       req_y;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_pix;

  modport slave (
    input  req_valid, req_x, req_y, mem_rd_data, res_ready,
    output req_ready, mem_rd_en, mem_addr, res_valid, res_pix
  );

  modport master (
    output req_valid, req_x, req_y, mem_rd_data, res_ready,
    input  req_ready, mem_rd_en, mem_addr, res_valid, res_pix
  );
endinterface

// File: rtl/bilin_weight_gen.sv
// Bilinear weight generator: four Q0.14 neighbour weights from the
// horizontal and vertical Q0.7 fractions. The four weights always sum
// to 16384.
module bilin_weight_gen
  import bilin_pkg::*;
(
  input  logic [FRAC_W-1:0] fx,
  input  logic [FRAC_W-1:0] fy,
  output logic [WGT_W-1:0]  w00,
  output logic [WGT_W-1:0]  w01,
  output logic [WGT_W-1:0]  w10,
  output logic [WGT_W-1:0]  w11
);

  logic [7:0] wx0_s;
  logic [7:0] wx1_s;
  logic [7:0] wy0_s;
  logic [7:0] wy1_s;

  // Per-axis weights and their outer products.
  always_comb begin
    wx1_s = {1'b0, fx};
    wy1_s = {1'b0, fy};
    wx0_s = 8'(ONE) - wx1_s;
    wy0_s = 8'(ONE) - wy1_s;
    w00   = WGT_W'(wx0_s) * WGT_W'(wy0_s);
    w01   = WGT_W'(wx1_s) * WGT_W'(wy0_s);
    w10   = WGT_W'(wx0_s) * WGT_W'(wy1_s);
    w11   = WGT_W'(wx1_s) * WGT_W'(wy1_s);
  end

endmodule

// File: rtl/bilin_fetch_ctrl.sv
// Bilinear fetch controller: accepts a Q6.7 coordinate, reads the four
// neighbouring pixels in order (p00, p01, p10, p11), accumulates the
// weighted sum and presents one rounded, saturated pixel.
// Optional feature macro: BILIN_EDGE_CLAMP_EN clamps neighbour and
// integer coordinates to the image bounds.
module bilin_fetch_ctrl
  import bilin_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  bilin_fetch_ctrl_if.slave bus
);

  if (IMG_W < 2 || IMG_W > 64) begin : g_bad_img_w
    $error("bilin_fetch_ctrl: IMG_W out of range 2..64");
  end
  if (IMG_H < 2 || IMG_H > 64) begin : g_bad_img_h
    $error("bilin_fetch_ctrl: IMG_H out of range 2..64");
  end

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         cnt_r;
  logic [INT_W-1:0]   x_int_r;
  logic [INT_W-1:0]   y_int_r;
  logic [FRAC_W-1:0]  fx_r;
  logic [FRAC_W-1:0]  fy_r;
  logic [ACC_W-1:0]   acc_r;
  logic               mem_rd_en_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               res_valid_r;
  logic [PIX_W-1:0]   res_pix_r;

  logic               accept_s;
  logic [INT_W-1:0]   xi_s;
  logic [INT_W-1:0]   yi_s;
  logic [1:0]         k_s;
  logic [6:0]         x0_s;
  logic [6:0]         x1_s;
  logic [6:0]         y0_s;
  logic [6:0]         y1_s;
  logic [6:0]         x_sel_s;
  logic [6:0]         y_sel_s;
  logic [ADDR_W-1:0]  addr_s;

  logic [WGT_W-1:0]   w00_s;
  logic [WGT_W-1:0]   w01_s;
  logic [WGT_W-1:0]   w10_s;
  logic [WGT_W-1:0]   w11_s;
  logic [1:0]         data_idx_s;
  logic [WGT_W-1:0]   w_sel_s;
  logic [ACC_W-1:0]   acc_next_s;

  bilin_weight_gen u_weight_gen (
    .fx  (fx_r),
    .fy  (fy_r),
    .w00 (w00_s),
    .w01 (w01_s),
    .w10 (w10_s),
    .w11 (w11_s)
  );

  assign accept_s      = (state_r == ST_IDLE) && bus.req_valid;
  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_pix   = res_pix_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (cnt_r == 2'd3) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (bus.res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Address of the next neighbour to read: neighbour 0 straight from the
  // request while idle, neighbours 1..3 from the captured coordinate.
  always_comb begin
    if (state_r == ST_IDLE) begin
      xi_s = bus.req_x[COORD_W-1:FRAC_W];
      yi_s = bus.req_y[COORD_W-1:FRAC_W];
      k_s  = 2'd0;
    end else begin
      xi_s = x_int_r;
      yi_s = y_int_r;
      k_s  = cnt_r + 2'd1;
    end
`ifdef BILIN_EDGE_CLAMP_EN
    if ({1'b0, xi_s} > 7'(IMG_W - 1)) begin
      x0_s = 7'(IMG_W - 1);
    end else begin
      x0_s = {1'b0, xi_s};
    end
    if ({1'b0, yi_s} > 7'(IMG_H - 1)) begin
      y0_s = 7'(IMG_H - 1);
    end else begin
      y0_s = {1'b0, yi_s};
    end
    if (x0_s >= 7'(IMG_W - 1)) begin
      x1_s = x0_s;
    end else begin
      x1_s = x0_s + 7'd1;
    end
    if (y0_s >= 7'(IMG_H - 1)) begin
      y1_s = y0_s;
    end else begin
      y1_s = y0_s + 7'd1;
    end
`else
    x0_s = {1'b0, xi_s};
    y0_s = {1'b0, yi_s};
    x1_s = x0_s + 7'd1;
    y1_s = y0_s + 7'd1;
`endif
    x_sel_s = k_s[0] ? x1_s : x0_s;
    y_sel_s = k_s[1] ? y1_s : y0_s;
    addr_s  = ADDR_W'(y_sel_s) * ADDR_W'(IMG_W) + ADDR_W'(x_sel_s);
  end

  // Weight for the pixel arriving this cycle (one cycle behind the read).
  always_comb begin
    if (state_r == ST_DRAIN) begin
      data_idx_s = 2'd3;
    end else begin
      data_idx_s = cnt_r - 2'd1;
    end
    case (data_idx_s)
      2'd0:    w_sel_s = w00_s;
      2'd1:    w_sel_s = w01_s;
      2'd2:    w_sel_s = w10_s;
      2'd3:    w_sel_s = w11_s;
      default: w_sel_s = w00_s;
    endcase
    acc_next_s = acc_r + ACC_W'(bus.mem_rd_data) * ACC_W'(w_sel_s);
  end

  // Request capture, read sequencing, multiply-accumulate and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= 2'd0;
      x_int_r     <= '0;
      y_int_r     <= '0;
      fx_r        <= '0;
      fy_r        <= '0;
      acc_r       <= '0;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= '0;
      res_valid_r <= 1'b0;
      res_pix_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_int_r     <= bus.req_x[COORD_W-1:FRAC_W];
            y_int_r     <= bus.req_y[COORD_W-1:FRAC_W];
            fx_r        <= bus.req_x[FRAC_W-1:0];
            fy_r        <= bus.req_y[FRAC_W-1:0];
            acc_r       <= '0;
            cnt_r       <= 2'd0;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= addr_s;
          end else begin
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= '0;
          end
        end
        ST_FETCH: begin
          if (cnt_r != 2'd0) begin
            acc_r <= acc_next_s;
          end else begin
            acc_r <= acc_r;
          end
          if (cnt_r == 2'd3) begin
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= '0;
          end else begin
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= addr_s;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        ST_DRAIN: begin
          acc_r       <= acc_next_s;
          res_pix_r   <= round_sat_pix(acc_next_s);
          res_valid_r <= 1'b1;
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
          end else begin
            res_valid_r <= 1'b1;
          end
        end
        default: begin
          mem_rd_en_r <= 1'b0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
